dual_issue_splitter: RTL and testbench
======================================

// Module: dual_issue_splitter
// PURPOSE
//  Registered dispatch stage directly downstream of the pair RAW/WAR hazard checker.
//  - Accepts an instruction pair from the issue queue, plus the checker's hazard_flag.
//  - Hazard-free pair: issues both in one cycle on lanes 0/1.
//  - Hazardous pair: splits it into two serial single issues on lane 0, older first.
//  - Guarantees no dependent pair ever reaches the execute lanes together.
// PARAMETERS
//  INST_W  32  width of one instruction word
//  REG_W    4  width of a register specifier; all-ones = "no destination"
//  CNT_W   16  width of split counter (only with SPLIT_CNT_EN)
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       synchronous, active-high reset
//  in_valid     in   1       pair offered by issue queue
//  in_ready     out  1       stage accepts pair this cycle
//  in_v1        in   1       slot 1 (older) holds a real instruction
//  in_v2        in   1       slot 2 (younger) holds a real instruction
//  in_inst1     in   INST_W  slot 1 instruction
//  in_inst2     in   INST_W  slot 2 instruction
//  hazard_flag  in   1       from hazard checker, same cycle as the pair
//  out_ready    in   1       execute lanes accept the current outputs
//  out_valid0   out  1       lane 0 valid (always the older instruction)
//  out_valid1   out  1       lane 1 valid
//  out_inst0    out  INST_W  lane 0 instruction
//  out_inst1    out  INST_W  lane 1 instruction
//  split_cnt    out  CNT_W   pairs split so far (SPLIT_CNT_EN only)
// BEHAVIOUR
//  - Reset: state=EMPTY; out_valid0/1=0; out_inst0/1=0; split_cnt=0; in_ready=0 while rst=1.
//  - Handshakes:
//    - Input transfer = in_valid & in_ready.
//    - Output transfer = out_ready & (out_valid0 | out_valid1).
//    - Outputs are registered and held stable until transferred.
//  - Latency: 1 cycle from input transfer to outputs valid. Throughput:
//    - 1 pair/cycle hazard-free.
//    - 1 pair/2 cycles split.
//  - Capture holds inst1, inst2, v1, v2, and split = hazard_flag & v1 & v2.
//    - hazard_flag is ignored unless both slots are valid.
//  - FSM:
//    - EMPTY: in_ready=1. On transfer: split ? SPLIT1 : PAIR. If in_v1=in_v2=0, the pair is dropped and state stays EMPTY.
//    - PAIR: lane0=first valid slot, lane1=inst2 only if both valid, else out_valid1=0.
//      - out_ready=1: in_ready=1. New transfer: split ? SPLIT1 : PAIR. No transfer: EMPTY.
//      - out_ready=0: hold.
//    - SPLIT1: lane0=inst1, out_valid1=0, in_ready=0.
//      - out_ready=1: SPLIT2.
//      - out_ready=0: hold.
//    - SPLIT2: lane0=inst2, out_valid1=0. Same exit rules as PAIR.
//  - Single-slot pair (only v2=1): inst2 is issued on lane 0. Lane 1 is never valid without lane 0.
//  - Back-to-back: a refill in the drain cycle is loss-free with no bubble.
//  - in_ready depends on out_ready combinationally. No other comb path from input to output.
//  - Reset mid-split: the remaining instruction is discarded; next cycle is EMPTY.
// CONFIGURATION
//  SPLIT_CNT_EN defined:
//   - split_cnt increments by 1 on each input transfer with split=1.
//   - It saturates at 2^CNT_W-1; no wrap.
//  SPLIT_CNT_EN undefined:
//   - No counter logic is built and split_cnt is tied to 0.
// TESTING
//  1 Reset 3 cycles, in_valid=1 -> in_ready=0, out_valid0/1=0 during reset; first accept on the cycle after rst falls.
//  2 Pair A=0x11,B=0x22, hazard=0, out_ready=1 -> next cycle lane0=0x11, lane1=0x22, both valid for 1 cycle.
//  3 Pair A,B with hazard=1 -> cycle+1 lane0=A only; cycle+2 lane0=B only; in_ready=0 in the SPLIT1 cycle; split_cnt=1.
//  4 Streaming 4 hazard-free pairs, out_ready=1 -> 4 consecutive dual issues, no bubble; out_ready=0 for 2 cycles mid-stream -> outputs held, nothing lost or duplicated.
//  5 v1=0,v2=1,inst2=0x33, hazard=1 -> single issue lane0=0x33, no split, split_cnt unchanged.
//  6 rst=1 in SPLIT1 -> B never issued; SPLIT_CNT_EN build: 2^CNT_W+3 hazard pairs -> split_cnt=all-ones.

Source files
------------

// File: rtl/dual_issue_splitter.sv
// Registered dispatch stage: issues hazard-free pairs on two lanes, serialises hazardous pairs on lane 0.
// Optional feature macro: SPLIT_CNT_EN (saturating count of split pairs on split_cnt).
module dual_issue_splitter #(
    parameter int unsigned INST_W = 32,
    parameter int unsigned REG_W  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_v1,
    input  logic              in_v2,
    input  logic [INST_W-1:0] in_inst1,
    input  logic [INST_W-1:0] in_inst2,
    input  logic              hazard_flag,
    input  logic              out_ready,
    output logic              out_valid0,
    output logic              out_valid1,
    output logic [INST_W-1:0] out_inst0,
    output logic [INST_W-1:0] out_inst1,
    output logic [CNT_W-1:0]  split_cnt
);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        PAIR   = 2'd1,
        SPLIT1 = 2'd2,
        SPLIT2 = 2'd3
    } state_t;

    // Register specifiers are resolved upstream; the width is only sanity-checked here.
    if (REG_W < 1) begin : g_reg_w_chk
        $error("REG_W must be at least 1");
    end

    state_t            state;
    state_t            state_nxt;
    logic [INST_W-1:0] inst2_q;
    logic [INST_W-1:0] inst2_nxt;
    logic              out_valid0_nxt;
    logic              out_valid1_nxt;
    logic [INST_W-1:0] out_inst0_nxt;
    logic [INST_W-1:0] out_inst1_nxt;
    logic              drainable;
    logic              in_xfer;
    logic              any_v;
    logic              split;

    // Last (or only) issue of a pair leaving this cycle frees the stage for a refill.
    assign drainable = ((state == PAIR) || (state == SPLIT2)) && out_ready;
    assign in_ready  = !rst && ((state == EMPTY) || drainable);
    assign in_xfer   = in_valid && in_ready;
    assign any_v     = in_v1 || in_v2;
    assign split     = hazard_flag && in_v1 && in_v2;

    always_comb begin
        state_nxt      = state;
        inst2_nxt      = inst2_q;
        out_valid0_nxt = out_valid0;
        out_valid1_nxt = out_valid1;
        out_inst0_nxt  = out_inst0;
        out_inst1_nxt  = out_inst1;

        if (in_xfer && any_v) begin
            inst2_nxt      = in_inst2;
            out_valid0_nxt = 1'b1;
            if (split) begin
                state_nxt      = SPLIT1;
                out_inst0_nxt  = in_inst1;
                out_valid1_nxt = 1'b0;
                out_inst1_nxt  = '0;
            end else begin
                state_nxt      = PAIR;
                out_inst0_nxt  = in_v1 ? in_inst1 : in_inst2;
                out_valid1_nxt = in_v1 && in_v2;
                out_inst1_nxt  = (in_v1 && in_v2) ? in_inst2 : '0;
            end
        end else if (drainable) begin
            state_nxt      = EMPTY;
            out_valid0_nxt = 1'b0;
            out_valid1_nxt = 1'b0;
        end else if ((state == SPLIT1) && out_ready) begin
            state_nxt      = SPLIT2;
            out_valid0_nxt = 1'b1;
            out_valid1_nxt = 1'b0;
            out_inst0_nxt  = inst2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            inst2_q    <= '0;
            out_valid0 <= 1'b0;
            out_valid1 <= 1'b0;
            out_inst0  <= '0;
            out_inst1  <= '0;
        end else begin
            state      <= state_nxt;
            inst2_q    <= inst2_nxt;
            out_valid0 <= out_valid0_nxt;
            out_valid1 <= out_valid1_nxt;
            out_inst0  <= out_inst0_nxt;
            out_inst1  <= out_inst1_nxt;
        end
    end

`ifdef SPLIT_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating count of accepted pairs that were split.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (in_xfer && split && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign split_cnt = cnt_q;
`else
    assign split_cnt = '0;
`endif

endmodule

// File: tb/tb_dual_issue_splitter.sv
// Self-checking bench for dual_issue_splitter: issue-group scoreboard plus directed literal checks.
module tb_dual_issue_splitter;

    localparam int unsigned INST_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
`ifdef SPLIT_CNT_EN
    localparam int          CNT_EN = 1;
`else
    localparam int          CNT_EN = 0;
`endif

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              in_v1;
    logic              in_v2;
    logic [INST_W-1:0] in_inst1;
    logic [INST_W-1:0] in_inst2;
    logic              hazard_flag;
    logic              out_ready;
    logic              out_valid0;
    logic              out_valid1;
    logic [INST_W-1:0] out_inst0;
    logic [INST_W-1:0] out_inst1;
    logic [CNT_W-1:0]  split_cnt;

    dual_issue_splitter #(.INST_W(INST_W), .REG_W(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_v1(in_v1), .in_v2(in_v2),
        .in_inst1(in_inst1), .in_inst2(in_inst2),
        .hazard_flag(hazard_flag), .out_ready(out_ready),
        .out_valid0(out_valid0), .out_valid1(out_valid1),
        .out_inst0(out_inst0), .out_inst1(out_inst1),
        .split_cnt(split_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic              dual;
        logic [INST_W-1:0] i0;
        logic [INST_W-1:0] i1;
    } grp_t;

    grp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;
    logic prev_rst = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pair(input logic v, input logic v1, input logic v2,
                            input logic [INST_W-1:0] i1, input logic [INST_W-1:0] i2,
                            input logic hz);
        in_valid    = v;
        in_v1       = v1;
        in_v2       = v2;
        in_inst1    = i1;
        in_inst2    = i2;
        hazard_flag = hz;
    endtask

    // Scoreboard: every accepted pair becomes one or two lane-0-first issue groups, released in order.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_in_ready", 64'(in_ready), 64'd0);
            if (prev_rst) begin
                check("rst_valid0", 64'(out_valid0), 64'd0);
                check("rst_valid1", 64'(out_valid1), 64'd0);
                check("rst_inst0", 64'(out_inst0), 64'd0);
                check("rst_split_cnt", 64'(split_cnt), 64'd0);
            end
            q.delete();
            exp_cnt = 0;
        end else begin
            check("in_ready", 64'(in_ready),
                  64'((q.size() == 0) || ((q.size() == 1) && out_ready)));
            check("lane0_valid", 64'(out_valid0), 64'(q.size() != 0));
            if (q.size() != 0) begin
                check("lane1_valid", 64'(out_valid1), 64'(q[0].dual));
                check("lane0_inst", 64'(out_inst0), 64'(q[0].i0));
                if (q[0].dual) check("lane1_inst", 64'(out_inst1), 64'(q[0].i1));
                if (out_ready) void'(q.pop_front());
            end else begin
                check("lane1_idle", 64'(out_valid1), 64'd0);
            end
            check("split_cnt", 64'(split_cnt), 64'(exp_cnt));
            if (in_valid && in_ready && (in_v1 || in_v2)) begin
                if (in_v1 && in_v2 && hazard_flag) begin
                    q.push_back('{dual: 1'b0, i0: in_inst1, i1: '0});
                    q.push_back('{dual: 1'b0, i0: in_inst2, i1: '0});
                    if (CNT_EN != 0 && exp_cnt < CNT_MAX) exp_cnt++;
                end else if (in_v1 && in_v2) begin
                    q.push_back('{dual: 1'b1, i0: in_inst1, i1: in_inst2});
                end else begin
                    q.push_back('{dual: 1'b0, i0: (in_v1 ? in_inst1 : in_inst2), i1: '0});
                end
            end
        end
        prev_rst = rst;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        set_pair(1'b1, 1'b1, 1'b1, 32'hAA, 32'hBB, 1'b0);

        // Reset held 3 cycles with a pair offered
        repeat (3) begin
            cyc();
            check("t1_in_ready", 64'(in_ready), 64'd0);
            check("t1_valid0", 64'(out_valid0), 64'd0);
            check("t1_valid1", 64'(out_valid1), 64'd0);
        end
        rst = 1'b0;
        #1;
        check("t1_first_accept", 64'(in_ready), 64'd1);
        cyc();
        check("t1_lane0", 64'(out_inst0), 64'hAA);

        // Hazard-free pair
        set_pair(1'b1, 1'b1, 1'b1, 32'h11, 32'h22, 1'b0);
        cyc();
        check("t2_lane0", 64'(out_inst0), 64'h11);
        check("t2_lane1", 64'(out_inst1), 64'h22);
        check("t2_valids", 64'({out_valid0, out_valid1}), 64'd3);
        set_pair(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        cyc();
        check("t2_one_cycle", 64'(out_valid0), 64'd0);

        // Hazardous pair splits into two serial issues
        set_pair(1'b1, 1'b1, 1'b1, 32'hA1, 32'hB2, 1'b1);
        cyc();
        set_pair(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("t3_split1_lane0", 64'(out_inst0), 64'hA1);
        check("t3_split1_valids", 64'({out_valid0, out_valid1}), 64'd2);
        check("t3_split1_in_ready", 64'(in_ready), 64'd0);
        cyc();
        check("t3_split2_lane0", 64'(out_inst0), 64'hB2);
        check("t3_split2_valids", 64'({out_valid0, out_valid1}), 64'd2);
        check("t3_split_cnt", 64'(split_cnt), 64'(CNT_EN));
        cyc();
        check("t3_done", 64'(out_valid0), 64'd0);

        // Streaming with a two-cycle stall mid-stream
        set_pair(1'b1, 1'b1, 1'b1, 32'h40, 32'h41, 1'b0);
        cyc();
        check("t4_p0", 64'({out_valid0, out_valid1, out_inst0}), {30'd0, 2'b11, 32'h40});
        set_pair(1'b1, 1'b1, 1'b1, 32'h42, 32'h43, 1'b0);
        cyc();
        check("t4_p1", 64'({out_valid0, out_valid1, out_inst0}), {30'd0, 2'b11, 32'h42});
        out_ready = 1'b0;
        set_pair(1'b1, 1'b1, 1'b1, 32'h44, 32'h45, 1'b0);
        #1;
        check("t4_stall_in_ready", 64'(in_ready), 64'd0);
        cyc();
        check("t4_hold_a", 64'({out_inst0, out_inst1}), {32'h42, 32'h43});
        cyc();
        check("t4_hold_b", 64'({out_inst0, out_inst1}), {32'h42, 32'h43});
        out_ready = 1'b1;
        cyc();
        check("t4_p2", 64'({out_valid0, out_valid1, out_inst0}), {30'd0, 2'b11, 32'h44});
        set_pair(1'b1, 1'b1, 1'b1, 32'h46, 32'h47, 1'b0);
        cyc();
        check("t4_p3", 64'({out_valid0, out_valid1, out_inst0}), {30'd0, 2'b11, 32'h46});
        set_pair(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        cyc();
        check("t4_done", 64'(out_valid0), 64'd0);

        // Younger slot only, hazard flag ignored; then older only; then an empty pair dropped
        set_pair(1'b1, 1'b0, 1'b1, 32'hEE, 32'h33, 1'b1);
        cyc();
        check("t5_v2_only", 64'({out_valid0, out_valid1, out_inst0}), {30'd0, 2'b10, 32'h33});
        set_pair(1'b1, 1'b1, 1'b0, 32'h55, 32'h66, 1'b1);
        cyc();
        check("t5_v1_only", 64'({out_valid0, out_valid1, out_inst0}), {30'd0, 2'b10, 32'h55});
        set_pair(1'b1, 1'b0, 1'b0, 32'h77, 32'h88, 1'b1);
        cyc();
        check("t5_dropped", 64'(out_valid0), 64'd0);
        check("t5_split_cnt", 64'(split_cnt), 64'(CNT_EN));
        set_pair(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        cyc();

        // Reset while the first half of a split is stalled
        out_ready = 1'b0;
        set_pair(1'b1, 1'b1, 1'b1, 32'hC1, 32'hC2, 1'b1);
        cyc();
        check("t6_split1_lane0", 64'(out_inst0), 64'hC1);
        set_pair(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        rst = 1'b1;
        cyc();
        check("t6_rst_valid0", 64'(out_valid0), 64'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        cyc();
        cyc();
        check("t6_b_discarded", 64'(out_valid0), 64'd0);
        check("t6_cnt_cleared", 64'(split_cnt), 64'd0);

        // Counter saturation: 2^CNT_W+3 hazardous pairs
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            int w;
            set_pair(1'b1, 1'b1, 1'b1, 32'h100 + 32'(i), 32'h200 + 32'(i), 1'b1);
            w = 0;
            while (!in_ready && w < 10) begin
                cyc();
                w++;
            end
            if (w >= 10) check("t6_accept_timeout", 64'(in_ready), 64'd1);
            cyc();
        end
        set_pair(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (3) cyc();
        check("t6_cnt_saturated", 64'(split_cnt), 64'(CNT_EN != 0 ? CNT_MAX : 0));
        check("drain_empty", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
